// File: rtl/yuv_stream_deformatter.sv
// yuv_stream_deformatter
//
// Receive side of the 32-bit YUV422 output stream. Incoming words are
// collected into four 32-bit lanes and emitted as one 128-bit word, which
// holds eight 16-bit pixels in the same layout the rgb_to_yuv stage produces.
// The first word of each group lands in [31:0] and the fourth in [127:96].
// The block also checks line length (words per line) and frame height
// (lines per frame) on the capture path.
//
// Ports
//   clk_i            rising-edge clock for all logic
//   reset_n_i        asynchronous, active-low reset
//   data_i           32-bit stream word
//   data_valid_i     data_i is valid this cycle
//   line_sync_i      high while a line is active
//   frame_sync_i     active low, low for the whole frame
//   data_o           packed 128-bit word; held between strobes
//   data_valid_o     one-cycle strobe, data_o is new
//   partial_o        qualifies data_valid_o: word was zero-padded at line close
//   line_end_o       one-cycle pulse when a line closes
//   frame_end_o      one-cycle pulse when a frame closes
//   line_len_err_o   with line_end_o: word count differed from WORDS_PER_LINE
//   frame_len_err_o  with frame_end_o: line count differed from LINES_PER_FRAME
//   line_count_o     lines closed so far in the current frame

module yuv_stream_deformatter #(
  parameter int unsigned WORDS_PER_LINE  = 120,
  parameter int unsigned LINES_PER_FRAME = 240,
  parameter int unsigned CNT_W           = 12
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic [31:0]      data_i,
  input  logic             data_valid_i,
  input  logic             line_sync_i,
  input  logic             frame_sync_i,
  output logic [127:0]     data_o,
  output logic             data_valid_o,
  output logic             partial_o,
  output logic             line_end_o,
  output logic             frame_end_o,
  output logic             line_len_err_o,
  output logic             frame_len_err_o,
  output logic [CNT_W-1:0] line_count_o
);

  typedef enum logic [1:0] {
    StIdle,
    StFrame,
    StLine
  } state_e;

  localparam logic [CNT_W-1:0] CntMax   = '1;
  localparam logic [CNT_W-1:0] WordsExp = CNT_W'(WORDS_PER_LINE);
  localparam logic [CNT_W-1:0] LinesExp = CNT_W'(LINES_PER_FRAME);

  state_e             state_q, state_d;
  logic [1:0]         lane_q, lane_d;
  // Lanes 0..2 of the word being assembled; lane 3 goes straight to data_o.
  logic [2:0][31:0]   buf_q, buf_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]   line_cnt_q, line_cnt_d;
  logic [CNT_W-1:0]   line_cnt_inc;
  logic [127:0]       data_q, data_d;
  logic               valid_q, valid_d;
  logic               partial_q, partial_d;
  logic               line_end_q, line_end_d;
  logic               frame_end_q, frame_end_d;
  logic               line_err_q, line_err_d;
  logic               frame_err_q, frame_err_d;
  // A frame closed from inside a line reports one cycle after its line_end.
  logic               frame_pend_q, frame_pend_d;
  logic               frame_pend_err_q, frame_pend_err_d;
  logic               accept;
  logic               close_line;

  assign line_cnt_inc = (line_cnt_q == CntMax) ? line_cnt_q : line_cnt_q + 1'b1;

  always_comb begin
    state_d          = state_q;
    lane_d           = lane_q;
    buf_d            = buf_q;
    word_cnt_d       = word_cnt_q;
    line_cnt_d       = line_cnt_q;
    data_d           = data_q;
    valid_d          = 1'b0;
    partial_d        = 1'b0;
    line_end_d       = 1'b0;
    frame_end_d      = 1'b0;
    line_err_d       = 1'b0;
    frame_err_d      = 1'b0;
    frame_pend_d     = 1'b0;
    frame_pend_err_d = 1'b0;
    accept           = 1'b0;
    close_line       = 1'b0;

    if (frame_pend_q) begin
      frame_end_d = 1'b1;
      frame_err_d = frame_pend_err_q;
    end

    unique case (state_q)
      StIdle: begin
        if (!frame_sync_i) begin
          state_d    = StFrame;
          line_cnt_d = '0;
        end
      end
      StFrame: begin
        if (frame_sync_i) begin
          state_d     = StIdle;
          frame_end_d = 1'b1;
          frame_err_d = (line_cnt_q != LinesExp);
        end else if (line_sync_i) begin
          state_d = StLine;
          accept  = data_valid_i;
        end
      end
      StLine: begin
        if (frame_sync_i || !line_sync_i) begin
          close_line = 1'b1;
        end else begin
          accept = data_valid_i;
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      word_cnt_d = (word_cnt_q == CntMax) ? word_cnt_q : word_cnt_q + 1'b1;
      if (lane_q == 2'd3) begin
        data_d    = {data_i, buf_q};
        valid_d   = 1'b1;
        partial_d = 1'b0;
        lane_d    = 2'd0;
      end else begin
        case (lane_q)
          2'd0:    buf_d[0] = data_i;
          2'd1:    buf_d[1] = data_i;
          default: buf_d[2] = data_i;
        endcase
        lane_d = lane_q + 2'd1;
      end
    end

    if (close_line) begin
      // Flush a part-filled word with its unfilled upper lanes zeroed.
      if (lane_q != 2'd0) begin
        valid_d   = 1'b1;
        partial_d = 1'b1;
        case (lane_q)
          2'd1:    data_d = {96'd0, buf_q[0]};
          2'd2:    data_d = {64'd0, buf_q[1], buf_q[0]};
          default: data_d = {32'd0, buf_q};
        endcase
      end
      line_end_d = 1'b1;
      line_err_d = (word_cnt_q != WordsExp);
      line_cnt_d = line_cnt_inc;
      word_cnt_d = '0;
      lane_d     = 2'd0;
      if (frame_sync_i) begin
        state_d          = StIdle;
        frame_pend_d     = 1'b1;
        frame_pend_err_d = (line_cnt_inc != LinesExp);
      end else begin
        state_d = StFrame;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q          <= StIdle;
      lane_q           <= 2'd0;
      buf_q            <= '0;
      word_cnt_q       <= '0;
      line_cnt_q       <= '0;
      data_q           <= '0;
      valid_q          <= 1'b0;
      partial_q        <= 1'b0;
      line_end_q       <= 1'b0;
      frame_end_q      <= 1'b0;
      line_err_q       <= 1'b0;
      frame_err_q      <= 1'b0;
      frame_pend_q     <= 1'b0;
      frame_pend_err_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      lane_q           <= lane_d;
      buf_q            <= buf_d;
      word_cnt_q       <= word_cnt_d;
      line_cnt_q       <= line_cnt_d;
      data_q           <= data_d;
      valid_q          <= valid_d;
      partial_q        <= partial_d;
      line_end_q       <= line_end_d;
      frame_end_q      <= frame_end_d;
      line_err_q       <= line_err_d;
      frame_err_q      <= frame_err_d;
      frame_pend_q     <= frame_pend_d;
      frame_pend_err_q <= frame_pend_err_d;
    end
  end

  assign data_o          = data_q;
  assign data_valid_o    = valid_q;
  assign partial_o       = partial_q;
  assign line_end_o      = line_end_q;
  assign frame_end_o     = frame_end_q;
  assign line_len_err_o  = line_err_q;
  assign frame_len_err_o = frame_err_q;
  assign line_count_o    = line_cnt_q;

endmodule

// File: tb/tb_yuv_stream_deformatter.sv
// Bench for yuv_stream_deformatter: drives whole frames/lines, predicts the
// ordered list of output events (packed words, line ends, frame ends) from the
// stream geometry, and compares it against the events the DUT produced.

module tb_yuv_stream_deformatter;

  localparam int unsigned WPL = 120;
  localparam int unsigned LPF = 240;
  localparam int unsigned CW  = 12;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [31:0]   data = '0;
  logic          data_valid = 1'b0;
  logic          line_sync = 1'b0;
  logic          frame_sync = 1'b1;
  logic [127:0]  data_o;
  logic          data_valid_o, partial_o, line_end_o, frame_end_o;
  logic          line_len_err_o, frame_len_err_o;
  logic [CW-1:0] line_count_o;

  yuv_stream_deformatter #(
    .WORDS_PER_LINE (WPL),
    .LINES_PER_FRAME(LPF),
    .CNT_W          (CW)
  ) dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n),
    .data_i         (data),
    .data_valid_i   (data_valid),
    .line_sync_i    (line_sync),
    .frame_sync_i   (frame_sync),
    .data_o         (data_o),
    .data_valid_o   (data_valid_o),
    .partial_o      (partial_o),
    .line_end_o     (line_end_o),
    .frame_end_o    (frame_end_o),
    .line_len_err_o (line_len_err_o),
    .frame_len_err_o(frame_len_err_o),
    .line_count_o   (line_count_o)
  );

  always #5 clk = ~clk;

  // kind: 0 packed word, 1 line end, 2 frame end, 3 qualifier without its strobe
  typedef struct packed {
    logic [1:0]    kind;
    logic          flag;
    logic [CW-1:0] cnt;
    logic [127:0]  data;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         obs_q[$];
  int          obs_cyc_q[$];
  int          wcyc_q[$];
  int          cyc = 0;
  int          close_cyc;
  int          n_vec = 0;
  int          n_err = 0;
  int          m_lines;
  logic [31:0] next_word;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t make_ev(input logic [1:0] k, input logic f, input logic [CW-1:0] c,
                                  input logic [127:0] d);
    ev_t e;
    e.kind = k;
    e.flag = f;
    e.cnt  = c;
    e.data = d;
    return e;
  endfunction

  // Event monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      if (data_valid_o) begin
        obs_q.push_back(make_ev(2'd0, partial_o, '0, data_o));
        obs_cyc_q.push_back(cyc);
      end
      if (line_end_o) begin
        obs_q.push_back(make_ev(2'd1, line_len_err_o, line_count_o, '0));
        obs_cyc_q.push_back(cyc);
      end
      if (frame_end_o) begin
        obs_q.push_back(make_ev(2'd2, frame_len_err_o, line_count_o, '0));
        obs_cyc_q.push_back(cyc);
      end
      if ((partial_o && !data_valid_o) || (line_len_err_o && !line_end_o) ||
          (frame_len_err_o && !frame_end_o)) begin
        obs_q.push_back(make_ev(2'd3, 1'b1, '0, '0));
        obs_cyc_q.push_back(cyc);
      end
    end
  end

  // Inputs set here are sampled by the following rising edge.
  task automatic drive(input logic fs, input logic ls, input logic dv, input logic [31:0] d);
    @(posedge clk);
    #1;
    frame_sync = fs;
    line_sync  = ls;
    data_valid = dv;
    data       = d;
  endtask

  task automatic clear_queues;
    exp_q.delete();
    obs_q.delete();
    obs_cyc_q.delete();
    wcyc_q.delete();
  endtask

  // Reference: a line of n words yields ceil(n/4) words, the last zero-padded
  // if n is not a multiple of 4, followed by a line end.
  task automatic model_line(input logic [31:0] w[$]);
    int n;
    logic [127:0] pk;
    n = w.size();
    for (int i = 0; i < n; i += 4) begin
      pk = '0;
      for (int j = 0; j < 4 && i + j < n; j++) pk[32*j +: 32] = w[i+j];
      exp_q.push_back(make_ev(2'd0, (n - i) < 4, '0, pk));
    end
    if (m_lines < 4095) m_lines++;
    exp_q.push_back(make_ev(2'd1, n != WPL, CW'(m_lines), '0));
  endtask

  task automatic frame_start;
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    m_lines = 0;
  endtask

  task automatic send_line(input int n, input bit gapped, input bit incr);
    logic [31:0] w[$];
    logic [31:0] v;
    for (int i = 0; i < n; i++) begin
      v = incr ? next_word : $urandom;
      next_word++;
      w.push_back(v);
      drive(1'b0, 1'b1, 1'b1, v);
      wcyc_q.push_back(cyc);
      if (gapped) drive(1'b0, 1'b1, 1'b0, $urandom);
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    close_cyc = cyc;
    model_line(w);
  endtask

  task automatic frame_stop;
    drive(1'b1, 1'b0, 1'b0, 32'd0);
    exp_q.push_back(make_ev(2'd2, m_lines != LPF, CW'(m_lines), '0));
    repeat (3) drive(1'b1, 1'b0, 1'b0, $urandom);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #13;
    n_vec++;
    if ({data_o, data_valid_o, partial_o, line_end_o, frame_end_o, line_len_err_o,
         frame_len_err_o, line_count_o} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got data=%h valid=%b cnt=%0d, required all zero",
               data_o, data_valid_o, line_count_o);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) drive(1'b1, 1'b0, 1'b1, $urandom);
    n_vec++;
    if (obs_q.size() != 0) begin
      n_err++;
      $display("FAIL reset_quiet: got %0d events, required 0", obs_q.size());
    end
  endtask

  task automatic test_nominal;
    clear_queues();
    next_word = 32'd0;
    frame_start();
    for (int l = 0; l < int'(LPF); l++) send_line(WPL, 1'b0, 1'b1);
    frame_stop();
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL nominal_count: got %0d events, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL nominal_ev%0d: got k=%0d f=%b c=%0d d=%h, required k=%0d f=%b c=%0d d=%h",
                 i, obs_q[i].kind, obs_q[i].flag, obs_q[i].cnt, obs_q[i].data,
                 exp_q[i].kind, exp_q[i].flag, exp_q[i].cnt, exp_q[i].data);
      end
    end
    n_vec++;
    if (obs_q.size() == 0 || obs_q[0].data !== {32'h3, 32'h2, 32'h1, 32'h0}) begin
      n_err++;
      $display("FAIL nominal_first_word: got %0d events / first %h, required %h", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[0].data : 128'd0, {32'h3, 32'h2, 32'h1, 32'h0});
    end
    n_vec++;
    if (obs_cyc_q.size() == 0 || obs_cyc_q[0] != wcyc_q[3] + 1) begin
      n_err++;
      $display("FAIL nominal_latency: got cycle %0d, required %0d",
               (obs_cyc_q.size() > 0) ? obs_cyc_q[0] : -1, wcyc_q[3] + 1);
    end
    // Last packed word of the frame is held after the final strobe.
    n_vec++;
    if (data_o !== exp_q[exp_q.size()-3].data) begin
      n_err++;
      $display("FAIL nominal_hold: got %h, required %h", data_o, exp_q[exp_q.size()-3].data);
    end
  endtask

  task automatic test_short_line;
    clear_queues();
    frame_start();
    send_line(WPL + 1, 1'b0, 1'b0);
    frame_stop();
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL short_count: got %0d events, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL short_ev%0d: got k=%0d f=%b c=%0d d=%h, required k=%0d f=%b c=%0d d=%h",
                 i, obs_q[i].kind, obs_q[i].flag, obs_q[i].cnt, obs_q[i].data,
                 exp_q[i].kind, exp_q[i].flag, exp_q[i].cnt, exp_q[i].data);
      end
    end
    n_vec++;
    if (obs_cyc_q.size() < 32 || obs_cyc_q[30] != close_cyc + 1 ||
        obs_cyc_q[31] != close_cyc + 1) begin
      n_err++;
      $display("FAIL short_flush_timing: got %0d events, required flush+line_end at cycle %0d",
               obs_cyc_q.size(), close_cyc + 1);
    end
  endtask

  task automatic test_gapped;
    clear_queues();
    frame_start();
    send_line(24, 1'b1, 1'b0);
    send_line(10, 1'b1, 1'b0);
    frame_stop();
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL gapped_count: got %0d events, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL gapped_ev%0d: got k=%0d f=%b c=%0d d=%h, required k=%0d f=%b c=%0d d=%h",
                 i, obs_q[i].kind, obs_q[i].flag, obs_q[i].cnt, obs_q[i].data,
                 exp_q[i].kind, exp_q[i].flag, exp_q[i].cnt, exp_q[i].data);
      end
    end
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (obs_cyc_q.size() < 6 || obs_cyc_q[i+1] - obs_cyc_q[i] != 8) begin
        n_err++;
        $display("FAIL gapped_spacing%0d: got %0d events / gap %0d, required gap 8", i,
                 obs_cyc_q.size(), (obs_cyc_q.size() >= 6) ? obs_cyc_q[i+1] - obs_cyc_q[i] : -1);
      end
    end
  endtask

  task automatic test_back_to_back;
    int lens[6];
    lens = '{4, 7, 1, 8, 13, 0};
    lens[5] = int'($urandom_range(2, 20));
    clear_queues();
    frame_start();
    foreach (lens[k]) send_line(lens[k], 1'b0, 1'b0);
    frame_stop();
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL b2b_count: got %0d events, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL b2b_ev%0d: got k=%0d f=%b c=%0d d=%h, required k=%0d f=%b c=%0d d=%h",
                 i, obs_q[i].kind, obs_q[i].flag, obs_q[i].cnt, obs_q[i].data,
                 exp_q[i].kind, exp_q[i].flag, exp_q[i].cnt, exp_q[i].data);
      end
    end
  endtask

  task automatic test_frame_abort;
    logic [31:0] w[$];
    int n;
    clear_queues();
    frame_start();
    for (int l = 0; l < 4; l++) send_line(int'($urandom_range(3, 10)), 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      w.push_back($urandom);
      drive(1'b0, 1'b1, 1'b1, w[i]);
    end
    drive(1'b1, 1'b1, 1'b1, $urandom);
    model_line(w);
    exp_q.push_back(make_ev(2'd2, m_lines != LPF, CW'(m_lines), '0));
    repeat (3) drive(1'b1, 1'b0, 1'b0, 32'd0);
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL abort_count: got %0d events, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL abort_ev%0d: got k=%0d f=%b c=%0d d=%h, required k=%0d f=%b c=%0d d=%h",
                 i, obs_q[i].kind, obs_q[i].flag, obs_q[i].cnt, obs_q[i].data,
                 exp_q[i].kind, exp_q[i].flag, exp_q[i].cnt, exp_q[i].data);
      end
    end
    n = obs_cyc_q.size();
    n_vec++;
    if (n < 3 || obs_cyc_q[n-3] != obs_cyc_q[n-2] || obs_cyc_q[n-1] != obs_cyc_q[n-2] + 1) begin
      n_err++;
      $display("FAIL abort_timing: got %0d events, required flush=line_end, frame_end one later",
               n);
    end
    n_vec++;
    if (line_count_o !== CW'(5)) begin
      n_err++;
      $display("FAIL abort_line_count: got %0d, required 5", line_count_o);
    end
  endtask

  task automatic test_async_reset;
    clear_queues();
    frame_start();
    send_line(6, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, $urandom);
    @(posedge clk);
    #2;
    n_vec++;
    if (obs_q.size() != exp_q.size() || (obs_q.size() == 3 && obs_q[1] !== exp_q[1])) begin
      n_err++;
      $display("FAIL rst_pre_events: got %0d events, required %0d", obs_q.size(), exp_q.size());
    end
    reset_n    = 1'b0;
    frame_sync = 1'b1;
    line_sync  = 1'b0;
    data_valid = 1'b0;
    #1;
    n_vec++;
    if ({data_o, data_valid_o, partial_o, line_end_o, frame_end_o, line_len_err_o,
         frame_len_err_o, line_count_o} !== '0) begin
      n_err++;
      $display("FAIL rst_async: got data=%h valid=%b cnt=%0d, required all zero",
               data_o, data_valid_o, line_count_o);
    end
    clear_queues();
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
    repeat (3) drive(1'b1, 1'b0, 1'b0, 32'd0);
    n_vec++;
    if (obs_q.size() != 0) begin
      n_err++;
      $display("FAIL rst_no_flush: got %0d events, required 0", obs_q.size());
    end
    frame_start();
    send_line(4, 1'b0, 1'b0);
    frame_stop();
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL rst_after_count: got %0d events, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL rst_after_ev%0d: got k=%0d f=%b c=%0d d=%h, required k=%0d f=%b c=%0d d=%h",
                 i, obs_q[i].kind, obs_q[i].flag, obs_q[i].cnt, obs_q[i].data,
                 exp_q[i].kind, exp_q[i].flag, exp_q[i].cnt, exp_q[i].data);
      end
    end
  endtask

  task automatic test_stray;
    clear_queues();
    frame_start();
    send_line(8, 1'b0, 1'b0);
    repeat (5) drive(1'b0, 1'b0, 1'b1, $urandom);
    n_vec++;
    if (line_count_o !== CW'(1)) begin
      n_err++;
      $display("FAIL stray_frame_count: got %0d, required 1", line_count_o);
    end
    // A full-length line right after the strays must report no length error.
    send_line(WPL, 1'b0, 1'b0);
    frame_stop();
    repeat (5) drive(1'b1, 1'b1, 1'b1, $urandom);
    n_vec++;
    if (line_count_o !== CW'(2)) begin
      n_err++;
      $display("FAIL stray_idle_count: got %0d, required 2", line_count_o);
    end
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL stray_count: got %0d events, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL stray_ev%0d: got k=%0d f=%b c=%0d d=%h, required k=%0d f=%b c=%0d d=%h",
                 i, obs_q[i].kind, obs_q[i].flag, obs_q[i].cnt, obs_q[i].data,
                 exp_q[i].kind, exp_q[i].flag, exp_q[i].cnt, exp_q[i].data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_short_line();
    test_gapped();
    test_back_to_back();
    test_frame_abort();
    test_async_reset();
    test_stray();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
